udp_tx: RTL
===========

// Module: udp_tx
// PURPOSE
//  Transmit half of UDP layer: takes user payload stream, prepends 8-byte UDP header as one 64-bit beat,
//  forwards to IP TX layer with IP sideband (length, protocol 17). Checksum field fixed 0 (IPv4-legal).
//  Sits between user logic and IP TX; mirror of UDP receive path (same header beat layout/user encoding).
// PARAMETERS
//  P_SRC_UDP_PORT  16'h0808  source port after reset until dynamic update
//  P_DST_UDP_PORT  16'h0808  destination port after reset until dynamic update
// PORTS
//  i_clk                 in   1   clock, all logic rising-edge
//  i_rst_n               in   1   reset, synchronous, active-low
//  i_dymanic_src_port    in   16  new source port
//  i_dymanic_src_valid   in   1   load i_dymanic_src_port
//  i_dymanic_dst_port    in   16  new destination port
//  i_dymanic_dst_valid   in   1   load i_dymanic_dst_port
//  s_axis_user_data      in   64  payload, first byte in [63:56]
//  s_axis_user_user      in   32  [15:0] payload byte length, stable whole packet; [31:16] ignored
//  s_axis_user_keep      in   8   byte enables, MSB-first; meaningful only on last
//  s_axis_user_last      in   1   last payload beat
//  s_axis_user_valid     in   1   payload beat valid
//  s_axis_user_ready     out  1   payload beat accepted when valid&ready
//  m_axis_ip_data        out  64  header beat then payload
//  m_axis_ip_user        out  56  [55:40] UDP length (payload+8), [36:29] 8'd17, all other bits 0
//  m_axis_ip_keep        out  8   8'hff except last beat
//  m_axis_ip_last        out  1   last beat of frame
//  m_axis_ip_valid       out  1   output beat valid
//  m_axis_ip_ready       in   1   downstream accept
//  o_len_err             out  1   (UDP_TX_LEN_CHECK_EN only) one-cycle length-mismatch pulse
// BEHAVIOUR
//  Reset (i_rst_n=0 at clock edge): src/dst port regs <= parameters; state IDLE; m_axis_ip_valid/last=0,
//   data=0, user=0, keep=8'hff; s_axis_user_ready=0; o_len_err=0. Reset mid-frame aborts frame, no last emitted.
//  Port regs: load on *_valid any cycle; value latched into header at IDLE->HEADER; mid-frame update affects next frame.
//  FSM: IDLE -> HEADER when s_axis_user_valid=1 (payload not consumed); latch len=s_axis_user_user[15:0].
//   HEADER: output reg loaded with {src,dst,len+16'd8,16'h0000}, keep 8'hff, user per PORTS; -> PAYLOAD
//    once header beat handshakes (m_valid&m_ready).
//   PAYLOAD: s_axis_user_ready = !m_axis_ip_valid || m_axis_ip_ready; accepted beat appears on m_axis_ip next cycle,
//    data/keep/last pass through; keep forced 8'hff when last=0. -> IDLE after input last accepted.
//  Output register: m_valid held with data stable until m_ready; no combinational path m_ready->m_data.
//  Latency: s_valid in IDLE -> header m_valid 1 cycle later; payload beat 1 cycle after acceptance.
//  Throughput: 1 beat/cycle in PAYLOAD with m_ready=1; one bubble (header) per frame; back-to-back frames:
//   IDLE entered same edge as last accept, next header starts following cycle.
//  Width: len+8 in 16 bits, wraps modulo 2^16 (len>65527 unsupported, no flag).
//  len==0: header beat carries m_last=1; the single input beat (must carry last) is accepted and discarded.
//  s_axis_user_ready=0 in IDLE and HEADER.
// CONFIGURATION
//  UDP_TX_LEN_CHECK_EN defined: beat counter vs ceil(len/8). Input last early -> o_len_err pulse, frame ends at
//   that beat. Count reached w/o input last -> emit m_last on beat ceil(len/8), o_len_err pulse, then keep
//   s_ready=1 and discard input beats until input last (state DRAIN), then IDLE.
//  Undefined: no counter, no DRAIN state, o_len_err tied 0; frame end strictly follows input last.
// TESTING
//  1 src=0x1234,dst=0x5678,len=16, 2 beats, m_ready=1 -> header 0x1234_5678_0018_0000, user[55:40]=24,
//    [36:29]=17, then 2 beats, last on 2nd, keep 8'hff.
//  2 len=13, 2 beats, last keep 8'hf8 -> header length 0x0015, last out keep 8'hf8, earlier keep 8'hff.
//  3 m_ready toggles 1,0,0,1 mid-payload -> no beat lost/duplicated, data stable while stalled, s_ready low when held.
//  4 i_dymanic_dst_valid with 0x9ABC during frame -> current header unchanged, next frame dst=0x9ABC.
//  5 i_rst_n=0 for 1 cycle mid-frame -> next cycle m_valid=0, s_ready=0; next frame header uses parameter ports.
//  6 (LEN_CHECK_EN) len=8, 3 input beats -> m_last on 1st payload beat, o_len_err 1 cycle, beats 2-3 dropped.

Source files
------------

// File: rtl/udp_tx.sv
// udp_tx: transmit half of the UDP layer.
//
// Takes a user payload stream, prepends the 8-byte UDP header as a single 64-bit beat
// {src_port, dst_port, udp_length, checksum=0} and forwards the frame to the IP TX layer.
// IP sideband on m_axis_ip_user: [55:40] UDP length (payload + 8), [36:29] protocol 17.
//
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_dymanic_src_port/valid  runtime source port update
//   i_dymanic_dst_port/valid  runtime destination port update
//   s_axis_user_*             payload stream in; user[15:0] = payload byte length
//   m_axis_ip_*               header + payload stream out, fully registered
//   o_len_err                 one-cycle pulse on payload length mismatch (length check only)
//
// Optional feature: define UDP_TX_LEN_CHECK_EN to count payload beats against ceil(len/8).
// An early input last ends the frame with an error pulse; reaching the count without input
// last forces m_axis_ip_last, pulses the error and drains input beats until input last.
// With the macro undefined there is no counter and o_len_err is tied low.

module udp_tx #(
  parameter logic [15:0] P_SRC_UDP_PORT = 16'h0808,
  parameter logic [15:0] P_DST_UDP_PORT = 16'h0808
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_dymanic_src_port,
  input  logic        i_dymanic_src_valid,
  input  logic [15:0] i_dymanic_dst_port,
  input  logic        i_dymanic_dst_valid,
  input  logic [63:0] s_axis_user_data,
  input  logic [31:0] s_axis_user_user,
  input  logic [7:0]  s_axis_user_keep,
  input  logic        s_axis_user_last,
  input  logic        s_axis_user_valid,
  output logic        s_axis_user_ready,
  output logic [63:0] m_axis_ip_data,
  output logic [55:0] m_axis_ip_user,
  output logic [7:0]  m_axis_ip_keep,
  output logic        m_axis_ip_last,
  output logic        m_axis_ip_valid,
  input  logic        m_axis_ip_ready,
  output logic        o_len_err
);

`ifdef UDP_TX_LEN_CHECK_EN
  typedef enum logic [1:0] {StIdle, StHeader, StPayload, StDrain} state_e;
`else
  typedef enum logic [1:0] {StIdle, StHeader, StPayload} state_e;
`endif

  state_e      state_q;
  logic [15:0] src_q, dst_q, len_q;
  logic [63:0] m_data_q;
  logic [55:0] m_user_q;
  logic [7:0]  m_keep_q;
  logic        m_last_q, m_valid_q;
  logic        len_err_q;

  logic [15:0] hdr_len;
  logic        s_hs;
  logic        out_free;

  // Upper user bits carry nothing for this layer.
  logic unused_user;
  assign unused_user = ^s_axis_user_user[31:16];

  assign hdr_len  = s_axis_user_user[15:0] + 16'd8;  // wraps modulo 2^16
  assign out_free = !m_valid_q || m_axis_ip_ready;
  assign s_hs     = s_axis_user_valid && s_axis_user_ready;

`ifdef UDP_TX_LEN_CHECK_EN
  logic [13:0] cnt_q;
  logic [13:0] cnt_inc;
  logic [13:0] target;
  assign cnt_inc = cnt_q + 14'd1;
  assign target  = {1'b0, len_q[15:3]} + {13'd0, |len_q[2:0]};  // ceil(len/8)
  assign s_axis_user_ready = ((state_q == StPayload) && out_free) || (state_q == StDrain);
`else
  assign s_axis_user_ready = (state_q == StPayload) && out_free;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      src_q     <= P_SRC_UDP_PORT;
      dst_q     <= P_DST_UDP_PORT;
      len_q     <= 16'd0;
      m_data_q  <= 64'd0;
      m_user_q  <= 56'd0;
      m_keep_q  <= 8'hff;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
      len_err_q <= 1'b0;
`ifdef UDP_TX_LEN_CHECK_EN
      cnt_q     <= 14'd0;
`endif
    end else begin
      len_err_q <= 1'b0;
      if (i_dymanic_src_valid) src_q <= i_dymanic_src_port;
      if (i_dymanic_dst_valid) dst_q <= i_dymanic_dst_port;
      // Beat consumed downstream; overridden below when a new beat is loaded.
      if (m_axis_ip_ready) m_valid_q <= 1'b0;

      case (state_q)
        StIdle: begin
          // Previous frame's last beat may still be waiting in the output register.
          if (s_axis_user_valid && out_free) begin
            len_q     <= s_axis_user_user[15:0];
            m_data_q  <= {src_q, dst_q, hdr_len, 16'h0000};
            m_user_q  <= {hdr_len, 3'b000, 8'd17, 29'd0};
            m_keep_q  <= 8'hff;
            m_last_q  <= (s_axis_user_user[15:0] == 16'd0);
            m_valid_q <= 1'b1;
            state_q   <= StHeader;
          end
        end

        StHeader: begin
          if (m_axis_ip_ready) begin
            state_q <= StPayload;
`ifdef UDP_TX_LEN_CHECK_EN
            cnt_q   <= 14'd0;
`endif
          end
        end

        StPayload: begin
          if (s_hs) begin
            if (len_q == 16'd0) begin
              // Empty payload: header already carried last, the input beat is dropped.
`ifdef UDP_TX_LEN_CHECK_EN
              if (s_axis_user_last) begin
                state_q <= StIdle;
              end else begin
                len_err_q <= 1'b1;
                state_q   <= StDrain;
              end
`else
              if (s_axis_user_last) state_q <= StIdle;
`endif
            end else begin
              m_data_q  <= s_axis_user_data;
              m_keep_q  <= s_axis_user_last ? s_axis_user_keep : 8'hff;
              m_last_q  <= s_axis_user_last;
              m_valid_q <= 1'b1;
`ifdef UDP_TX_LEN_CHECK_EN
              cnt_q <= cnt_inc;
              if (s_axis_user_last) begin
                state_q <= StIdle;
                if (cnt_inc != target) len_err_q <= 1'b1;
              end else if (cnt_inc == target) begin
                m_last_q  <= 1'b1;
                len_err_q <= 1'b1;
                state_q   <= StDrain;
              end
`else
              if (s_axis_user_last) state_q <= StIdle;
`endif
            end
          end
        end

`ifdef UDP_TX_LEN_CHECK_EN
        StDrain: begin
          if (s_axis_user_valid && s_axis_user_last) state_q <= StIdle;
        end
`endif

        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_axis_ip_data  = m_data_q;
  assign m_axis_ip_user  = m_user_q;
  assign m_axis_ip_keep  = m_keep_q;
  assign m_axis_ip_last  = m_last_q;
  assign m_axis_ip_valid = m_valid_q;
  assign o_len_err       = len_err_q;

endmodule
